uart_tx_core: RTL and testbench

- Serial UART transmitter with an integrated baud-tick generator.
- Sends one 8N1-style frame: 1 start bit (0), WORD_BITS data bits LSB first, 1 stop bit (1).
- Sits between a byte producer and the board TX pin.
- Single clock domain; every output is registered.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_tx_core.sv | 138 +++++++++++++
 tb/tb_uart_tx_core.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter slice: transmitter state encoding,
// default frame geometry and the divider formula for the baud-tick generator.
package uart_pkg;

  localparam int unsigned WordBitsDefault    = 8;
  localparam int unsigned SampleTicksDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Clock cycles per baud tick for a given clock, baud rate and oversampling factor.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned sample_ticks);
    return clk_hz / baud / sample_ticks;
  endfunction

  // 100 MHz clock at 9600 baud, 16x oversampling -> 651.
  localparam int unsigned BaudDivDefault = baud_div(100_000_000, 9600, SampleTicksDefault);

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running mod-BAUD_DIV counter. The tick is a registered one-cycle pulse that is
// high exactly while the counter holds BAUD_DIV-1.
// Ports:
//   clk_i    - system clock, rising edge
//   reset_i  - synchronous active-low reset
//   tick_o   - one-cycle baud tick
//   count_o  - current counter value
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault,
  parameter int unsigned CNT_BITS = $clog2(BAUD_DIV)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  output logic                tick_o,
  output logic [CNT_BITS-1:0] count_o
);

  localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(BAUD_DIV - 1);

  logic [CNT_BITS-1:0] count_q, count_d;
  logic                tick_q, tick_d;

  always_comb begin
    count_d = (count_q == CntMax) ? '0 : count_q + CNT_BITS'(1);
    // Registered so the tick lines up with the cycle in which count_q == CntMax.
    tick_d  = (count_d == CntMax);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o  = tick_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: one start bit (0), WORD_BITS data bits LSB first, one stop bit (1),
// each bit lasting SAMPLE_TICKS baud ticks. The baud tick generator is free-running and
// is exported so a receiver can share it. All outputs come straight from flops.
// Ports:
//   clk_i         - system clock, rising edge
//   reset_i       - synchronous active-low reset; aborts any frame in flight
//   tx_start_i    - send request, only looked at while idle
//   data_i        - word to send, captured when the frame starts
//   tx_o          - serial line, idles high
//   tx_done_o     - one-cycle pulse when the stop bit completes
//   baud_tick_o   - one-cycle baud tick
//   baud_count_o  - current baud counter value
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned WORD_BITS    = WordBitsDefault,
  parameter int unsigned SAMPLE_TICKS = SampleTicksDefault,
  parameter int unsigned BAUD_DIV     = BaudDivDefault,
  parameter int unsigned CNT_BITS     = $clog2(BAUD_DIV)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 tx_start_i,
  input  logic [WORD_BITS-1:0] data_i,
  output logic                 tx_o,
  output logic                 tx_done_o,
  output logic                 baud_tick_o,
  output logic [CNT_BITS-1:0]  baud_count_o
);

  localparam int unsigned SW = $clog2(SAMPLE_TICKS);
  localparam int unsigned NW = $clog2(WORD_BITS);
  localparam logic [SW-1:0] SMax = SW'(SAMPLE_TICKS - 1);
  localparam logic [NW-1:0] NMax = NW'(WORD_BITS - 1);

  logic tick;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV),
    .CNT_BITS (CNT_BITS)
  ) u_baud_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_o  (tick),
    .count_o (baud_count_o)
  );

  assign baud_tick_o = tick;

  tx_state_e            state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [WORD_BITS-1:0] b_q, b_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = tick && (s_q == SMax);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_start_i) begin
          b_d     = data_i;
          s_d     = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          s_d     = '0;
          n_d     = '0;
          state_d = StData;
        end else if (tick) begin
          s_d = s_q + SW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          s_d = '0;
          b_d = b_q >> 1;
          if (n_q == NMax) begin
            state_d = StStop;
          end else begin
            n_d = n_q + NW'(1);
          end
        end else if (tick) begin
          s_d = s_q + SW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          s_d     = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (tick) begin
          s_d = s_q + SW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level follows the state being entered so tx_o changes on the same edge.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = b_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx_o      = tx_q;
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

  localparam int unsigned WB     = 8;
  localparam int unsigned ST     = 16;
  localparam int unsigned BD     = 4;
  localparam int unsigned CB     = 2;
  localparam int unsigned BitCyc = ST * BD;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tx_start = 1'b0;
  logic [WB-1:0] data = '0;
  logic          tx;
  logic          done;
  logic          tick;
  logic [CB-1:0] cnt;

  uart_tx_core #(
    .WORD_BITS    (WB),
    .SAMPLE_TICKS (ST),
    .BAUD_DIV     (BD),
    .CNT_BITS     (CB)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_n),
    .tx_start_i   (tx_start),
    .data_i       (data),
    .tx_o         (tx),
    .tx_done_o    (done),
    .baud_tick_o  (tick),
    .baud_count_o (cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected line sequences in transmission order, leftmost bit first.
  logic [9:0] exp_q[$];
  bit         mon_en = 1'b1;

  logic prev_tx = 1'b1;
  int   high_run = 0;
  always @(negedge clk) begin
    prev_tx  <= tx;
    high_run <= (tx === 1'b1) ? high_run + 1 : 0;
  end

  int done_cnt = 0;
  initial begin
    logic dp;
    dp = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        check("done_one_cycle_wide", {31'd0, dp}, 32'd0);
      end
      dp = done;
    end
  end

  // Frame monitor: on each falling edge, sample mid-bit and compare to the queue.
  int unsigned last_done_cyc = 0;
  initial begin
    logic [9:0] e;
    bit         got;
    forever begin
      @(negedge clk);
      if (mon_en && prev_tx === 1'b1 && tx === 1'b0) begin
        if (cyc - last_done_cyc <= 2)
          check("stop_bit_not_shortened", {31'd0, high_run >= int'(BitCyc)}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < 10; k++) begin
            repeat ((k == 0) ? BitCyc / 2 : BitCyc) @(negedge clk);
            check($sformatf("frame_%03h_bit%0d", e, k), {31'd0, tx}, {31'd0, e[9-k]});
          end
          got = 1'b0;
          for (int i = 0; i < 2 * int'(BitCyc) && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
          end
          check("done_after_stop", {31'd0, got}, 32'd1);
          last_done_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_done(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    check(nm, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_tick(output int unsigned at, output bit got);
    got = 1'b0;
    at  = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        got = 1'b1;
        at  = cyc;
      end
    end
  endtask

  task automatic pulse_start(input logic [WB-1:0] d);
    @(negedge clk);
    data     = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  initial begin
    int unsigned t0, t1, d0, lows;
    bit g0, g1;

    // Reset held for two edges.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_tx_high", {31'd0, tx}, 32'd1);
    check("reset_done_low", {31'd0, done}, 32'd0);
    check("reset_count_zero", {30'd0, cnt}, 32'd0);
    check("reset_tick_low", {31'd0, tick}, 32'd0);
    reset_n = 1'b1;

    // Baud tick: fires at count BD-1, period BD.
    wait_tick(t0, g0);
    check("tick_seen", {31'd0, g0}, 32'd1);
    check("tick_at_count_max", {30'd0, cnt}, 32'd3);
    wait_tick(t1, g1);
    check("tick_period", t1 - t0, 32'd4);

    // 0x55 with start held for 10 cycles; line must drop on the first edge.
    @(negedge clk);
    data = 8'h55;
    exp_q.push_back(10'b0_10101010_1);
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    check("start_latency_1cyc", {31'd0, tx}, 32'd0);
    repeat (9) @(negedge clk);
    tx_start = 1'b0;
    wait_done("done_55");

    // Reset while idle, then 0xCC.
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(10'b0_00110011_1);
    pulse_start(8'hCC);
    wait_done("done_cc");

    // Start held across two frames: exactly two back-to-back frames.
    repeat (3) @(negedge clk);
    data = 8'h0F;
    exp_q.push_back(10'b0_11110000_1);
    exp_q.push_back(10'b0_11110000_1);
    tx_start = 1'b1;
    wait_done("done_0f_first");
    wait_done("done_0f_second");
    tx_start = 1'b0;

    // data_i changes mid-frame must not affect the latched word.
    repeat (3) @(negedge clk);
    exp_q.push_back(10'b0_11000101_1);
    pulse_start(8'hA3);
    repeat (200) @(negedge clk);
    data = 8'hFF;
    wait_done("done_a3");

    // Reset during DATA aborts the frame.
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    pulse_start(8'h00);
    repeat (200) @(negedge clk);
    check("abort_pre_line_low", {31'd0, tx}, 32'd0);
    d0 = done_cnt;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_tx_high", {31'd0, tx}, 32'd1);
    check("abort_done_low", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    lows = 0;
    repeat (800) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("abort_line_stays_high", lows, 32'd0);
    check("abort_no_done", done_cnt - d0, 32'd0);
    mon_en = 1'b1;

    check("queue_drained", exp_q.size(), 32'd0);
    check("total_done_pulses", done_cnt, 32'd5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: run exceeded 60000 cycles, got timeout, expected completion");
    $fatal(1);
  end

endmodule
